cr_transform: RTL and testbench

CR_TRANSFORM -- requirements
Module: cr_transform

---
 rtl/cr_transform.sv | 143 ++++++++++++++
 tb/tb_cr_transform.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/cr_transform.sv
// cr_transform: maps a raw Cr sample into the skin-cluster-normalised Cr'
// domain: Cr' = (Cr - Cr_c) * W_CR / W_cr + CR_CENTER_KH. When the local
// width is 0, the luma lies inside [k_l, k_h] and the sample passes through.
// The result is computed with a multi-cycle FSM:
// IDLE -> MULT -> DIV (36 cycles, restoring) -> FIX -> DONE.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   cr_value       raw Cr sample, unsigned 8-bit integer
//   width_cr       local Cr width W_cr(Y), (9,9) unsigned; 0 selects bypass
//   center_cr      local Cr centre Cr_c(Y), (9,9) unsigned
//   in_valid       qualifies the three input operands
//   in_ready       high while IDLE; the sample is accepted on valid && ready
//   cr_prime       transformed Cr', unsigned 8-bit integer
//   cr_prime_valid qualifies cr_prime; held until cr_prime_ready
//   cr_prime_ready downstream acceptance of cr_prime
module cr_transform #(
  parameter logic [17:0] W_CR         = 18'd19968,
  parameter logic [17:0] CR_CENTER_KH = 18'd78848
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  cr_value,
  input  logic [17:0] width_cr,
  input  logic [17:0] center_cr,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  cr_prime,
  output logic        cr_prime_valid,
  input  logic        cr_prime_ready
);

  typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_t;

  state_t             state;
  state_t             state_next;

  logic               diff_sign;
  logic [17:0]        diff_mag;
  logic [17:0]        width_q;
  // Holds the product during MULT; during DIV the dividend shifts out of the
  // top while quotient bits shift in at the bottom, so it ends as the quotient.
  logic [35:0]        acc;
  logic [17:0]        rem;
  logic [5:0]         iter;

  logic signed [18:0] diff_c;
  logic [17:0]        mag_c;
  logic [18:0]        rem_shift;
  logic               rem_ge;
  logic [17:0]        rem_sub;
  logic [17:0]        q_sat;
  logic signed [19:0] q_mag20;
  logic signed [19:0] q_signed;
  logic signed [19:0] sum;
  logic [7:0]         fix_c;

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = (width_cr == 18'd0) ? DONE : MULT;
      MULT: state_next = DIV;
      DIV:  if (iter == 6'd35) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: if (cr_prime_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand prep, one restoring-division step, and the final fix-up.
  always_comb begin
    // Cr is integer, so Cr in (9,9) is {cr,9'b0}; the result spans 19 signed bits.
    diff_c    = $signed({2'b00, cr_value, 9'b0}) - $signed({1'b0, center_cr});
    mag_c     = diff_c[18] ? 18'(-diff_c) : diff_c[17:0];
    rem_shift = {rem, acc[35]};
    rem_ge    = (rem_shift >= {1'b0, width_q});
    rem_sub   = 18'(rem_shift - {1'b0, width_q});
    // The quotient has 9 fractional bits; anything past 18 bits saturates.
    q_sat     = (|acc[35:18]) ? 18'h3FFFF : acc[17:0];
    q_mag20   = $signed({2'b00, q_sat});
    q_signed  = diff_sign ? -q_mag20 : q_mag20;
    sum       = q_signed + $signed({2'b00, CR_CENTER_KH});
    // Clamp the integer part to [0,255]; 131072 is 256.0 in (9,9).
    if (sum[19])                   fix_c = 8'd0;
    else if (sum >= 20'sd131072)   fix_c = 8'd255;
    else                           fix_c = sum[16:9];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cr_prime_valid <= 1'b0;
      cr_prime       <= 8'd0;
      iter           <= 6'd0;
      diff_sign      <= 1'b0;
      diff_mag       <= 18'd0;
      width_q        <= 18'd0;
      acc            <= 36'd0;
      rem            <= 18'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (width_cr == 18'd0) begin
              cr_prime       <= cr_value;
              cr_prime_valid <= 1'b1;
            end else begin
              diff_sign <= diff_c[18];
              diff_mag  <= mag_c;
              width_q   <= width_cr;
            end
          end
        end
        MULT: begin
          acc  <= 36'(diff_mag) * 36'(W_CR);
          rem  <= 18'd0;
          iter <= 6'd0;
        end
        DIV: begin
          acc  <= {acc[34:0], rem_ge};
          rem  <= rem_ge ? rem_sub : rem_shift[17:0];
          iter <= iter + 6'd1;
        end
        FIX: begin
          cr_prime       <= fix_c;
          cr_prime_valid <= 1'b1;
        end
        DONE: begin
          if (cr_prime_ready) cr_prime_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cr_transform.sv
// tb_cr_transform: directed and randomized checks of cr_transform against
// an arithmetic reference of the Cr' transfer function.
module tb_cr_transform;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cr_value;
  logic [17:0] width_cr;
  logic [17:0] center_cr;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  cr_prime;
  logic        cr_prime_valid;
  logic        cr_prime_ready;

  int checks = 0;
  int errors = 0;

  cr_transform dut (
    .clk            (clk),
    .rst            (rst),
    .cr_value       (cr_value),
    .width_cr       (width_cr),
    .center_cr      (center_cr),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .cr_prime       (cr_prime),
    .cr_prime_valid (cr_prime_valid),
    .cr_prime_ready (cr_prime_ready)
  );

  always #5 clk = ~clk;

  // Reference transfer: real-valued formula evaluated in (9,9) integers with
  // truncating division, 18-bit quotient saturation, floor, then clamp.
  function automatic int expectedCr(int cr, int width, int center);
    longint d, m, q, v;
    if (width == 0) return cr;
    d = longint'(cr) * 512 - longint'(center);
    m = (d < 0) ? -d : d;
    q = (m * 19968) / longint'(width);
    if (q > 262143) q = 262143;
    v = ((d < 0) ? -q : q) + 78848;
    v = v >>> 9;
    if (v < 0)   return 0;
    if (v > 255) return 255;
    return int'(v);
  endfunction

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  // Present a sample and wait (bounded) for the accepting edge.
  task automatic applyStimulus(int cr, int width, int center);
    int n = 0;
    cr_value  = 8'(cr);
    width_cr  = 18'(width);
    center_cr = 18'(center);
    in_valid  = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("accept_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges after acceptance until valid, scrambling the inputs (with
  // in_valid high) while busy; then check value, hold under backpressure,
  // and the output handshake.
  task automatic awaitResult(string tag, int expVal, int expLat, int hold);
    int lat = 0;
    while (!cr_prime_valid && lat < 60) begin
      cr_value  = 8'($urandom);
      width_cr  = 18'($urandom);
      center_cr = 18'($urandom);
      in_valid  = 1'b1;
      @(posedge clk); #1; lat++;
    end
    in_valid = 1'b0;
    checkOutput({tag, "_latency"}, lat, expLat);
    checkOutput({tag, "_value"}, {24'd0, cr_prime}, expVal);
    cr_prime_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput({tag, "_hold_value"}, {24'd0, cr_prime}, expVal);
      checkOutput({tag, "_hold_valid"}, {31'd0, cr_prime_valid}, 32'd1);
      checkOutput({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    cr_prime_ready = 1'b1;
    @(posedge clk); #1;
    cr_prime_ready = 1'b0;
    checkOutput({tag, "_drop_valid"}, {31'd0, cr_prime_valid}, 32'd0);
    checkOutput({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic runSample(string tag, int cr, int width, int center, int hold);
    applyStimulus(cr, width, center);
    awaitResult(tag, expectedCr(cr, width, center), (width == 0) ? 0 : 38, hold);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; cr_prime_ready = 1'b0;
    cr_value = 8'd0; width_cr = 18'd0; center_cr = 18'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_valid", {31'd0, cr_prime_valid}, 32'd0);
    checkOutput("reset_cr_prime", {24'd0, cr_prime}, 32'd0);

    runSample("bypass", 120, 0, 0, 10);
    runSample("zero_offset", 150, 19968, 76800, 2);
    runSample("scale_pos", 160, 9984, 76800, 0);
    runSample("sign_neg", 140, 19968, 76800, 10);
    runSample("sat_high", 255, 512, 51200, 1);
    runSample("sat_low", 0, 512, 102400, 1);

    // Reset while the divider is running aborts the sample.
    applyStimulus(200, 700, 40000);
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rst_div_valid", {31'd0, cr_prime_valid}, 32'd0);
    checkOutput("rst_div_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (45) begin
      @(posedge clk); #1;
      if (cr_prime_valid) break;
    end
    checkOutput("rst_div_no_output", {31'd0, cr_prime_valid}, 32'd0);
    runSample("after_reset", 150, 19968, 76800, 0);

    for (int i = 0; i < 30; i++) begin
      int w;
      case ($urandom_range(0, 3))
        0:       w = 0;
        1:       w = $urandom_range(1, 2048);
        default: w = $urandom_range(1, 262143);
      endcase
      runSample("random", $urandom_range(0, 255), w, $urandom_range(0, 262143),
                $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
